// File: rtl/io_control_sequencer.sv
// Hardwired fetch/execute control unit for the Mini SRC I/O and special-register move group.
// Drives Datapath control inputs as Moore decodes of the sequencer state and the IR opcode.
module io_control_sequencer #(
  parameter int unsigned READ_WAIT = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IR,
  input  logic             Stop,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Rin,
  output logic             Rout,
  output logic             InPortout,
  output logic             Out_Portin,
  output logic             HIout,
  output logic             LOout,
  output logic             Run,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_count
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CTRL_W = 17;

  localparam int unsigned B_PCOUT = 16, B_MARIN = 15, B_INCPC = 14, B_ZIN = 13;
  localparam int unsigned B_ZLOWOUT = 12, B_PCIN = 11, B_READ = 10, B_MDRIN = 9;
  localparam int unsigned B_MDROUT = 8, B_IRIN = 7, B_GRA = 6, B_RIN = 5, B_ROUT = 4;
  localparam int unsigned B_INPORTOUT = 3, B_OUTPORTIN = 2, B_HIOUT = 1, B_LOOUT = 0;

  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {T0, T1, T2, T3, HALT} state_t;

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt, next_wait_cnt;
  logic [CTRL_W-1:0]   ctrl;
  logic                illegal_d;
  logic                run_d;
  logic [4:0]          opcode;
  logic                unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];

  // State, read-wait counter and retired-instruction counter
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= T0;
      wait_cnt    <= '0;
      Instr_count <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait_cnt;
      if (state == T3) Instr_count <= Instr_count + CNT_W'(1);
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state    = state;
    next_wait_cnt = wait_cnt;
    ctrl          = '0;
    illegal_d     = 1'b0;
    run_d         = 1'b1;
    case (state)
      T0: begin
        ctrl[B_PCOUT] = 1'b1;
        ctrl[B_MARIN] = 1'b1;
        ctrl[B_INCPC] = 1'b1;
        ctrl[B_ZIN]   = 1'b1;
        next_wait_cnt = '0;
        next_state    = T1;
      end
      T1: begin
        ctrl[B_READ]    = 1'b1;
        ctrl[B_MDRIN]   = 1'b1;
        ctrl[B_ZLOWOUT] = 1'b1;
        next_wait_cnt   = wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(READ_WAIT)) begin
          ctrl[B_PCIN] = 1'b1;
          next_state   = T2;
        end
      end
      T2: begin
        ctrl[B_MDROUT] = 1'b1;
        ctrl[B_IRIN]   = 1'b1;
        next_state     = T3;
      end
      T3: begin
        case (opcode)
          OP_IN: begin
            ctrl[B_INPORTOUT] = 1'b1;
            ctrl[B_GRA]       = 1'b1;
            ctrl[B_RIN]       = 1'b1;
          end
          OP_OUT: begin
            ctrl[B_GRA]       = 1'b1;
            ctrl[B_ROUT]      = 1'b1;
            ctrl[B_OUTPORTIN] = 1'b1;
          end
          OP_MFHI: begin
            ctrl[B_HIOUT] = 1'b1;
            ctrl[B_GRA]   = 1'b1;
            ctrl[B_RIN]   = 1'b1;
          end
          OP_MFLO: begin
            ctrl[B_LOOUT] = 1'b1;
            ctrl[B_GRA]   = 1'b1;
            ctrl[B_RIN]   = 1'b1;
          end
          OP_NOP, OP_HALT: ;
          default: illegal_d = 1'b1;
        endcase
        next_state = (opcode == OP_HALT || Stop) ? HALT : T0;
      end
      HALT: run_d = 1'b0;
      default: next_state = T0;
    endcase
  end

  // Controls are forced low while Reset is held; state already sits in T0 so Run reads 1
  assign {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
          Gra, Rin, Rout, InPortout, Out_Portin, HIout, LOout} = Reset ? '0 : ctrl;
  assign Illegal = Reset ? 1'b0 : illegal_d;
  assign Run     = run_d;

endmodule

// File: tb/tb_io_control_sequencer.sv
// Bench for io_control_sequencer: two instances (READ_WAIT=0/CNT_W=16 and READ_WAIT=3/CNT_W=4)
// share inputs and are compared each cycle against a cycle-position model, plus literal pins.
module tb_io_control_sequencer;

  localparam logic [31:0] IR_IN   = 32'hB080_0000;
  localparam logic [31:0] IR_OUT  = 32'hB880_0000;
  localparam logic [31:0] IR_MFHI = 32'hC000_0000;
  localparam logic [31:0] IR_MFLO = 32'hC800_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;

  // Control vector order: PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin
  //                       Gra Rin Rout InPortout Out_Portin HIout LOout
  localparam logic [16:0] M_PCOUT = 17'h10000, M_MARIN = 17'h08000, M_INCPC = 17'h04000;
  localparam logic [16:0] M_ZIN = 17'h02000, M_ZLOW = 17'h01000, M_PCIN = 17'h00800;
  localparam logic [16:0] M_READ = 17'h00400, M_MDRIN = 17'h00200, M_MDROUT = 17'h00100;
  localparam logic [16:0] M_IRIN = 17'h00080, M_GRA = 17'h00040, M_RIN = 17'h00020;
  localparam logic [16:0] M_ROUT = 17'h00010, M_INP = 17'h00008, M_OUTP = 17'h00004;
  localparam logic [16:0] M_HI = 17'h00002, M_LO = 17'h00001;
  localparam logic [16:0] BUS_MASK = M_PCOUT | M_ZLOW | M_MDROUT | M_INP | M_ROUT | M_HI | M_LO;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR    = IR_IN;
  logic        Stop  = 1'b0;

  logic [16:0] c0, c3;
  logic        run0, run3, ill0, ill3;
  logic [15:0] cnt0;
  logic [3:0]  cnt3;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  int  m_k[2];
  bit  m_halt[2];
  int  m_cnt[2];

  always #5 Clock = ~Clock;

  io_control_sequencer #(.READ_WAIT(0), .CNT_W(16)) dut0 (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
    .PCout(c0[16]), .MARin(c0[15]), .IncPC(c0[14]), .Zin(c0[13]),
    .Zlowout(c0[12]), .PCin(c0[11]), .Read(c0[10]), .MDRin(c0[9]),
    .MDRout(c0[8]), .IRin(c0[7]), .Gra(c0[6]), .Rin(c0[5]), .Rout(c0[4]),
    .InPortout(c0[3]), .Out_Portin(c0[2]), .HIout(c0[1]), .LOout(c0[0]),
    .Run(run0), .Illegal(ill0), .Instr_count(cnt0)
  );

  io_control_sequencer #(.READ_WAIT(3), .CNT_W(4)) dut3 (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
    .PCout(c3[16]), .MARin(c3[15]), .IncPC(c3[14]), .Zin(c3[13]),
    .Zlowout(c3[12]), .PCin(c3[11]), .Read(c3[10]), .MDRin(c3[9]),
    .MDRout(c3[8]), .IRin(c3[7]), .Gra(c3[6]), .Rin(c3[5]), .Rout(c3[4]),
    .InPortout(c3[3]), .Out_Portin(c3[2]), .HIout(c3[1]), .LOout(c3[0]),
    .Run(run3), .Illegal(ill3), .Instr_count(cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {Run, Illegal, controls} from the position k within an instruction of 4+rw cycles
  function automatic logic [18:0] model_out(input int rw, input int k, input bit halted,
                                            input bit rst, input logic [4:0] op);
    logic [16:0] c;
    logic ill, run;
    c = '0; ill = 1'b0; run = 1'b1;
    if (rst) begin
      c = '0;
    end else if (halted) begin
      run = 1'b0;
    end else if (k == 0) begin
      c = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    end else if (k <= rw + 1) begin
      c = M_READ | M_MDRIN | M_ZLOW | ((k == rw + 1) ? M_PCIN : 17'h0);
    end else if (k == rw + 2) begin
      c = M_MDROUT | M_IRIN;
    end else begin
      case (op)
        5'b10110: c = M_INP | M_GRA | M_RIN;
        5'b10111: c = M_GRA | M_ROUT | M_OUTP;
        5'b11000: c = M_HI | M_GRA | M_RIN;
        5'b11001: c = M_LO | M_GRA | M_RIN;
        5'b11010, 5'b11011: c = '0;
        default: ill = 1'b1;
      endcase
    end
    return {run, ill, c};
  endfunction

  // Reference model: instruction position, halt flag and retired count per instance
  always @(posedge Clock or posedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_k[i]    <= 0;
        m_halt[i] <= 1'b0;
        m_cnt[i]  <= 0;
      end else if (!m_halt[i]) begin
        if (m_k[i] == ((i == 0) ? 3 : 6)) begin
          m_k[i]    <= 0;
          m_cnt[i]  <= (m_cnt[i] + 1) % ((i == 0) ? 65536 : 16);
          m_halt[i] <= (IR[31:27] == 5'b11011) || Stop;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [18:0] exp, act;
        exp = model_out((i == 0) ? 0 : 3, m_k[i], m_halt[i], Reset, IR[31:27]);
        act = (i == 0) ? {run0, ill0, c0} : {run3, ill3, c3};
        check((i == 0) ? "outs_rw0" : "outs_rw3", 32'(act), 32'(exp));
        check((i == 0) ? "cnt_rw0" : "cnt_rw3",
              (i == 0) ? 32'(cnt0) : 32'(cnt3), 32'(m_cnt[i]));
        check("bus_exclusive", 32'($countones(act[16:0] & BUS_MASK) <= 1), 32'(1));
      end
    end
  end

  initial begin
    // Reset held: controls low, Run high, counters zero
    repeat (3) @(posedge Clock);
    chk_en = 1'b1;
    @(negedge Clock);
    check("rst_ctrl0", 32'(c0), 32'h0);
    check("rst_run0", 32'(run0), 32'h1);
    check("rst_cnt0", 32'(cnt0), 32'h0);
    check("rst_ctrl3", 32'(c3), 32'h0);

    // READ_WAIT=0 fetch of "in"
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock); check("in_t0", 32'(c0), 32'h1E000);
    @(negedge Clock); check("in_t1", 32'(c0), 32'h01E00);
    @(negedge Clock); check("in_t2", 32'(c0), 32'h00180);
    @(negedge Clock); check("in_t3", 32'(c0), 32'h00068);
    @(posedge Clock); #1 IR = IR_OUT;
    @(negedge Clock);
    check("in_cnt", 32'(cnt0), 32'h1);
    check("in_back_t0", 32'(c0), 32'h1E000);
    repeat (3) @(negedge Clock); check("out_t3", 32'(c0), 32'h00054);
    @(posedge Clock); #1 IR = IR_MFHI;
    repeat (4) @(negedge Clock); check("mfhi_t3", 32'(c0), 32'h00062);
    @(posedge Clock); #1 IR = IR_MFLO;
    repeat (4) @(negedge Clock); check("mflo_t3", 32'(c0), 32'h00061);
    @(posedge Clock); #1 IR = IR_ILL;
    repeat (4) @(negedge Clock);
    check("ill_t3_ctrl", 32'(c0), 32'h0);
    check("ill_t3_flag", 32'(ill0), 32'h1);
    @(posedge Clock); #1 IR = IR_HALT;
    @(negedge Clock);
    check("ill_after_flag", 32'(ill0), 32'h0);
    check("ill_after_cnt", 32'(cnt0), 32'h5);
    check("ill_after_t0", 32'(c0), 32'h1E000);
    repeat (3) @(negedge Clock); check("halt_t3", 32'(c0), 32'h0);
    repeat (20) @(negedge Clock);
    check("halt_run", 32'(run0), 32'h0);
    check("halt_cnt", 32'(cnt0), 32'h6);
    check("halt_ctrl", 32'(c0), 32'h0);

    // READ_WAIT=3 fetch of nop, Stop raised during T1
    @(posedge Clock); #1 begin Reset = 1'b1; IR = IR_NOP; end
    @(negedge Clock);
    check("rst2_run0", 32'(run0), 32'h1);
    check("rst2_cnt0", 32'(cnt0), 32'h0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock); check("rw3_t0", 32'(c3), 32'h1E000);
    @(posedge Clock); #1 Stop = 1'b1;
    @(negedge Clock); check("rw3_t1a", 32'(c3), 32'h01600);
    @(negedge Clock); check("rw3_t1b", 32'(c3), 32'h01600);
    @(negedge Clock); check("rw3_t1c", 32'(c3), 32'h01600);
    @(negedge Clock); check("rw3_t1d", 32'(c3), 32'h01E00);
    @(negedge Clock); check("rw3_t2", 32'(c3), 32'h00180);
    @(negedge Clock); check("rw3_t3", 32'(c3), 32'h0);
    @(negedge Clock);
    check("stop_run3", 32'(run3), 32'h0);
    check("stop_cnt3", 32'(cnt3), 32'h1);
    check("stop_run0", 32'(run0), 32'h0);
    check("stop_cnt0", 32'(cnt0), 32'h1);

    // Asynchronous reset in the middle of the READ_WAIT=3 T1 window
    @(posedge Clock); #1 begin Reset = 1'b1; Stop = 1'b0; end
    @(posedge Clock); #1 Reset = 1'b0;
    repeat (8) @(negedge Clock); check("pre_arst_cnt3", 32'(cnt3), 32'h1);
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("arst_ctrl3", 32'(c3), 32'h0);
    check("arst_cnt3", 32'(cnt3), 32'h0);
    check("arst_run3", 32'(run3), 32'h1);
    check("arst_cnt0", 32'(cnt0), 32'h0);

    // Restart and counter wrap on the 4-bit instance
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock); check("restart_t0", 32'(c3), 32'h1E000);
    repeat (105) @(negedge Clock);
    check("pre_wrap_cnt3", 32'(cnt3), 32'hF);
    check("pre_wrap_cnt0", 32'(cnt0), 32'd26);
    repeat (7) @(negedge Clock);
    check("wrap_cnt3", 32'(cnt3), 32'h0);
    check("wrap_cnt0", 32'(cnt0), 32'd28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
